// File: rtl/issueq_wakeup_if.sv
// Issue-queue wakeup bus: dispatch writes, wakeup broadcast, select feedback
// and the request/occupancy view returned by the queue.
interface issueq_wakeup_if #(
  parameter int SIZE_ISSUEQ    = 32,
  parameter int DISPATCH_WIDTH = 4,
  parameter int ISSUE_WIDTH    = 4,
  parameter int PHYS_LOG       = 7
);
  localparam int IDX = $clog2(SIZE_ISSUEQ);

  logic                                     flush_i;
  logic [DISPATCH_WIDTH-1:0]                dispValid_i;
  logic [DISPATCH_WIDTH-1:0][IDX-1:0]       dispEntry_i;
  logic [DISPATCH_WIDTH-1:0][PHYS_LOG-1:0]  dispSrc1_i;
  logic [DISPATCH_WIDTH-1:0][PHYS_LOG-1:0]  dispSrc2_i;
  logic [DISPATCH_WIDTH-1:0]                dispSrc1Rdy_i;
  logic [DISPATCH_WIDTH-1:0]                dispSrc2Rdy_i;
  logic [ISSUE_WIDTH-1:0][PHYS_LOG-1:0]     wakeTag_i;
  logic [ISSUE_WIDTH-1:0]                   wakeValid_i;
  logic [SIZE_ISSUEQ-1:0]                   grantVect_i;
  logic [SIZE_ISSUEQ-1:0]                   freeVect_i;
  logic [SIZE_ISSUEQ-1:0]                   replayVect_i;
  logic [SIZE_ISSUEQ-1:0]                   reqVect_o;
  logic [IDX:0]                             occupancy_o;

  modport master (
    output flush_i, dispValid_i, dispEntry_i, dispSrc1_i, dispSrc2_i,
           dispSrc1Rdy_i, dispSrc2Rdy_i, wakeTag_i, wakeValid_i,
           grantVect_i, freeVect_i, replayVect_i,
    input  reqVect_o, occupancy_o
  );

  modport slave (
    input  flush_i, dispValid_i, dispEntry_i, dispSrc1_i, dispSrc2_i,
           dispSrc1Rdy_i, dispSrc2Rdy_i, wakeTag_i, wakeValid_i,
           grantVect_i, freeVect_i, replayVect_i,
    output reqVect_o, occupancy_o
  );
endinterface

// File: rtl/issueq_wakeup.sv
// Issue-queue wakeup array: tracks per-entry operand readiness and schedule
// state, and presents a request vector to the select logic.
module issueq_wakeup #(
  parameter int SIZE_ISSUEQ    = 32,
  parameter int DISPATCH_WIDTH = 4,
  parameter int ISSUE_WIDTH    = 4,
  parameter int PHYS_LOG       = 7
) (
  input logic           clk,
  input logic           reset,
  issueq_wakeup_if.slave bus
);
  localparam int IDX = $clog2(SIZE_ISSUEQ);
  localparam int CNT = IDX + 1;

  typedef logic [PHYS_LOG-1:0] tag_t;

  logic [SIZE_ISSUEQ-1:0] valid, sched, rdy1, rdy2;
  logic [SIZE_ISSUEQ-1:0] validN, schedN, rdy1N, rdy2N;
  tag_t [SIZE_ISSUEQ-1:0] tag1, tag2, tag1N, tag2N;
  logic [CNT-1:0]         occupancy;

  // Per-entry view of the dispatch lanes after lane arbitration.
  logic [SIZE_ISSUEQ-1:0] dispHit, dispR1, dispR2;
  tag_t [SIZE_ISSUEQ-1:0] dispT1, dispT2;

  function automatic logic wakeHit(
    input tag_t                              tag,
    input logic [ISSUE_WIDTH-1:0]            wv,
    input logic [ISSUE_WIDTH-1:0][PHYS_LOG-1:0] wt
  );
    wakeHit = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++)
      if (wv[k] && wt[k] == tag) wakeHit = 1'b1;
  endfunction

  function automatic logic [CNT-1:0] popcount(input logic [SIZE_ISSUEQ-1:0] v);
    popcount = '0;
    for (int i = 0; i < SIZE_ISSUEQ; i++) popcount = popcount + CNT'(v[i]);
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dispHit = '0;
    dispR1  = '0;
    dispR2  = '0;
    dispT1  = '0;
    dispT2  = '0;
    // Ascending lane order: a later (higher) lane overwrites an earlier one.
    for (int d = 0; d < DISPATCH_WIDTH; d++) begin
      for (int i = 0; i < SIZE_ISSUEQ; i++) begin
        if (bus.dispValid_i[d] && bus.dispEntry_i[d] == IDX'(i)) begin
          dispHit[i] = 1'b1;
          dispT1[i]  = bus.dispSrc1_i[d];
          dispT2[i]  = bus.dispSrc2_i[d];
          dispR1[i]  = bus.dispSrc1Rdy_i[d] |
                       wakeHit(bus.dispSrc1_i[d], bus.wakeValid_i, bus.wakeTag_i);
          dispR2[i]  = bus.dispSrc2Rdy_i[d] |
                       wakeHit(bus.dispSrc2_i[d], bus.wakeValid_i, bus.wakeTag_i);
        end
      end
    end
  end

  always_comb begin
    validN = valid;
    schedN = sched;
    rdy1N  = rdy1;
    rdy2N  = rdy2;
    tag1N  = tag1;
    tag2N  = tag2;
    for (int i = 0; i < SIZE_ISSUEQ; i++) begin
      if (bus.flush_i) begin
        validN[i] = 1'b0;
        schedN[i] = 1'b0;
        rdy1N[i]  = 1'b0;
        rdy2N[i]  = 1'b0;
      end else if (dispHit[i]) begin
        validN[i] = 1'b1;
        schedN[i] = 1'b0;
        tag1N[i]  = dispT1[i];
        tag2N[i]  = dispT2[i];
        rdy1N[i]  = dispR1[i];
        rdy2N[i]  = dispR2[i];
      end else if (bus.freeVect_i[i]) begin
        validN[i] = 1'b0;
        schedN[i] = 1'b0;
        rdy1N[i]  = 1'b0;
        rdy2N[i]  = 1'b0;
      end else if (valid[i]) begin
        // Replay outranks grant on the schedule bit; wakeup only touches rdy.
        if (bus.replayVect_i[i])     schedN[i] = 1'b0;
        else if (bus.grantVect_i[i]) schedN[i] = 1'b1;
        if (wakeHit(tag1[i], bus.wakeValid_i, bus.wakeTag_i)) rdy1N[i] = 1'b1;
        if (wakeHit(tag2[i], bus.wakeValid_i, bus.wakeTag_i)) rdy2N[i] = 1'b1;
      end
    end
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid     <= '0;
      sched     <= '0;
      rdy1      <= '0;
      rdy2      <= '0;
      occupancy <= '0;
    end else begin
      valid     <= validN;
      sched     <= schedN;
      rdy1      <= rdy1N;
      rdy2      <= rdy2N;
      occupancy <= popcount(validN);
    end
  end

  // NOTE: tag storage is deliberately unreset; a tag is only consulted while its entry is valid.
  always_ff @(posedge clk) begin
    tag1 <= tag1N;
    tag2 <= tag2N;
  end

  assign bus.reqVect_o   = valid & ~sched & rdy1 & rdy2;
  assign bus.occupancy_o = occupancy;
endmodule

// File: tb/tb_issueq_wakeup.sv
// Directed bench for issueq_wakeup: wakeup, bypass, grant/replay, fill,
// free/dispatch interplay, flush and reset behaviour.
module tb_issueq_wakeup;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  issueq_wakeup_if #(.SIZE_ISSUEQ(32), .DISPATCH_WIDTH(4), .ISSUE_WIDTH(4), .PHYS_LOG(7)) bus ();

  issueq_wakeup #(.SIZE_ISSUEQ(32), .DISPATCH_WIDTH(4), .ISSUE_WIDTH(4), .PHYS_LOG(7)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.flush_i       = 1'b0;
    bus.dispValid_i   = '0;
    bus.dispEntry_i   = '0;
    bus.dispSrc1_i    = '0;
    bus.dispSrc2_i    = '0;
    bus.dispSrc1Rdy_i = '0;
    bus.dispSrc2Rdy_i = '0;
    bus.wakeTag_i     = '0;
    bus.wakeValid_i   = '0;
    bus.grantVect_i   = '0;
    bus.freeVect_i    = '0;
    bus.replayVect_i  = '0;
  endtask

  task automatic setDisp(input int lane, input int entry, input int s1, input bit r1,
                         input int s2, input bit r2);
    bus.dispValid_i[lane]   = 1'b1;
    bus.dispEntry_i[lane]   = 5'(entry);
    bus.dispSrc1_i[lane]    = 7'(s1);
    bus.dispSrc2_i[lane]    = 7'(s2);
    bus.dispSrc1Rdy_i[lane] = r1;
    bus.dispSrc2Rdy_i[lane] = r2;
  endtask

  task automatic setWake(input int lane, input int tag);
    bus.wakeValid_i[lane] = 1'b1;
    bus.wakeTag_i[lane]   = 7'(tag);
  endtask

  task automatic doReset;
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    doReset();
    checks++;
    if (bus.occupancy_o !== 6'd0) begin
      failures++; $display("FAIL reset_occ got=%0d exp=0", bus.occupancy_o);
    end
    checks++;
    if (bus.reqVect_o !== 32'h0) begin
      failures++; $display("FAIL reset_req got=%h exp=0", bus.reqVect_o);
    end
  endtask

  task automatic test_wakeup;
    doReset();
    setDisp(0, 5, 12, 1'b1, 20, 1'b0);
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0) begin
      failures++; $display("FAIL wake_before got=%h exp=0", bus.reqVect_o);
    end
    // Matching tag on a lane with valid low must be ignored.
    bus.wakeTag_i[0] = 7'd20;
    bus.wakeTag_i[1] = 7'd0;
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0) begin
      failures++; $display("FAIL wake_invalid_lane got=%h exp=0", bus.reqVect_o);
    end
    setWake(2, 20);
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0000_0020) begin
      failures++; $display("FAIL wake_after got=%h exp=00000020", bus.reqVect_o);
    end
    checks++;
    if (bus.occupancy_o !== 6'd1) begin
      failures++; $display("FAIL wake_occ got=%0d exp=1", bus.occupancy_o);
    end
  endtask

  task automatic test_bypass;
    doReset();
    setDisp(1, 3, 9, 1'b0, 1, 1'b1);
    setWake(0, 9);
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0000_0008) begin
      failures++; $display("FAIL bypass_req got=%h exp=00000008", bus.reqVect_o);
    end
  endtask

  task automatic test_grant_replay;
    doReset();
    setDisp(0, 7, 2, 1'b1, 3, 1'b1);
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0000_0080) begin
      failures++; $display("FAIL gr_ready got=%h exp=00000080", bus.reqVect_o);
    end
    bus.grantVect_i[7] = 1'b1;
    bus.grantVect_i[8] = 1'b1;  // invalid entry, must stay empty
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0) begin
      failures++; $display("FAIL gr_granted got=%h exp=0", bus.reqVect_o);
    end
    checks++;
    if (bus.occupancy_o !== 6'd1) begin
      failures++; $display("FAIL gr_occ got=%0d exp=1", bus.occupancy_o);
    end
    bus.replayVect_i[7] = 1'b1;
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0000_0080) begin
      failures++; $display("FAIL gr_replay got=%h exp=00000080", bus.reqVect_o);
    end
    bus.grantVect_i[7] = 1'b1;
    step(); idle();
    // Replay wins over grant in the same cycle.
    bus.grantVect_i[7]  = 1'b1;
    bus.replayVect_i[7] = 1'b1;
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0000_0080) begin
      failures++; $display("FAIL gr_replay_prio got=%h exp=00000080", bus.reqVect_o);
    end
  endtask

  task automatic test_fill;
    doReset();
    for (int c = 0; c < 8; c++) begin
      for (int l = 0; l < 4; l++) setDisp(l, c * 4 + l, 40 + l, 1'b1, 50 + c, 1'b1);
      step(); idle();
    end
    checks++;
    if (bus.occupancy_o !== 6'd32) begin
      failures++; $display("FAIL fill_occ got=%0d exp=32", bus.occupancy_o);
    end
    checks++;
    if (bus.reqVect_o !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL fill_req got=%h exp=ffffffff", bus.reqVect_o);
    end
    bus.freeVect_i = 32'h0000_0007;
    setDisp(0, 0, 60, 1'b1, 61, 1'b1);
    setDisp(1, 1, 62, 1'b1, 63, 1'b0);
    step(); idle();
    checks++;
    if (bus.occupancy_o !== 6'd31) begin
      failures++; $display("FAIL fill_free_occ got=%0d exp=31", bus.occupancy_o);
    end
    checks++;
    if (bus.reqVect_o !== 32'hFFFF_FFF9) begin
      failures++; $display("FAIL fill_free_req got=%h exp=fffffff9", bus.reqVect_o);
    end
  endtask

  task automatic test_free_dispatch;
    doReset();
    setDisp(0, 10, 30, 1'b1, 31, 1'b1);
    step(); idle();
    bus.freeVect_i[10] = 1'b1;
    setDisp(3, 10, 40, 1'b0, 41, 1'b1);
    step(); idle();
    checks++;
    if (bus.occupancy_o !== 6'd1 || bus.reqVect_o !== 32'h0) begin
      failures++; $display("FAIL fd_redisp got occ=%0d req=%h exp occ=1 req=0",
                           bus.occupancy_o, bus.reqVect_o);
    end
    setWake(1, 30);  // old tag, must not wake
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0) begin
      failures++; $display("FAIL fd_oldtag got=%h exp=0", bus.reqVect_o);
    end
    setWake(3, 40);
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0000_0400) begin
      failures++; $display("FAIL fd_newtag got=%h exp=00000400", bus.reqVect_o);
    end
    // Two lanes target entry 11: lane 2 (not ready) must win over lane 0.
    setDisp(0, 11, 44, 1'b1, 45, 1'b1);
    setDisp(2, 11, 50, 1'b0, 51, 1'b1);
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0000_0400 || bus.occupancy_o !== 6'd2) begin
      failures++; $display("FAIL fd_lane_prio got occ=%0d req=%h exp occ=2 req=00000400",
                           bus.occupancy_o, bus.reqVect_o);
    end
    bus.flush_i = 1'b1;
    for (int l = 0; l < 4; l++) setDisp(l, 20 + l, 1, 1'b1, 2, 1'b1);
    step(); idle();
    checks++;
    if (bus.occupancy_o !== 6'd0 || bus.reqVect_o !== 32'h0) begin
      failures++; $display("FAIL fd_flush got occ=%0d req=%h exp occ=0 req=0",
                           bus.occupancy_o, bus.reqVect_o);
    end
  endtask

  task automatic test_reset_mid;
    doReset();
    for (int c = 0; c < 4; c++) begin
      for (int l = 0; l < 4; l++) setDisp(l, c * 4 + l, 70, 1'b1, 64, 1'b0);
      step(); idle();
    end
    checks++;
    if (bus.occupancy_o !== 6'd16 || bus.reqVect_o !== 32'h0) begin
      failures++; $display("FAIL rm_fill got occ=%0d req=%h exp occ=16 req=0",
                           bus.occupancy_o, bus.reqVect_o);
    end
    reset = 1'b0;
    setWake(0, 64);
    setDisp(0, 20, 1, 1'b1, 2, 1'b1);
    step(); idle();
    reset = 1'b1;
    checks++;
    if (bus.occupancy_o !== 6'd0 || bus.reqVect_o !== 32'h0) begin
      failures++; $display("FAIL rm_reset got occ=%0d req=%h exp occ=0 req=0",
                           bus.occupancy_o, bus.reqVect_o);
    end
    setWake(1, 64);
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0 || bus.occupancy_o !== 6'd0) begin
      failures++; $display("FAIL rm_stale got occ=%0d req=%h exp occ=0 req=0",
                           bus.occupancy_o, bus.reqVect_o);
    end
  endtask

  task automatic test_back_to_back;
    doReset();
    // Dispatch, wake and grant on consecutive cycles for two entries.
    setDisp(0, 1, 5, 1'b0, 6, 1'b1);
    setDisp(1, 2, 7, 1'b1, 8, 1'b1);
    step(); idle();
    setWake(3, 5);
    bus.grantVect_i[2] = 1'b1;
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0000_0002) begin
      failures++; $display("FAIL b2b_req got=%h exp=00000002", bus.reqVect_o);
    end
    bus.freeVect_i[2] = 1'b1;
    bus.grantVect_i[1] = 1'b1;
    step(); idle();
    checks++;
    if (bus.reqVect_o !== 32'h0 || bus.occupancy_o !== 6'd1) begin
      failures++; $display("FAIL b2b_free got occ=%0d req=%h exp occ=1 req=0",
                           bus.occupancy_o, bus.reqVect_o);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle();
    test_reset();
    test_wakeup();
    test_bypass();
    test_grant_replay();
    test_fill();
    test_free_dispatch();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
